// File: rtl/sensor_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_scheduler
//
// Time-multiplexes the SR04 ultrasonic controller and the DHT11 controller so
// that only one sensor is measuring at any time. Periodic timers and the
// manual run button raise per-sensor pending flags. An FSM serves one flag at
// a time: it issues a one-cycle start pulse, then waits for that sensor's done
// pulse or a timeout. Good results are latched into stable registers for the
// display mux. Failures set sticky error bits.
//
// Interface protocol: there is no valid/ready handshake on this block. Every
// control signal is a one-cycle pulse. A start pulse is fire-and-forget. A
// done pulse is sampled only in the matching WAIT state and is dropped
// otherwise. o_dist_vld / o_env_vld pulse for the one cycle after the result
// registers change.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   i_enable      1 = automatic period timers run
//   i_manual_req  pulse: request both sensors
//   i_sr04_done   pulse: SR04 measurement finished, i_sr04_dist valid
//   i_sr04_dist   SR04 distance in cm
//   i_dht_done    pulse: DHT11 transaction finished
//   i_dht_valid   checksum ok, qualifies i_dht_done
//   i_dht_hum     humidity, integer part in [15:8]
//   i_dht_temp    temperature, integer part in [15:8]
//   o_sr04_start  start pulse to SR04 controller
//   o_dht_start   start pulse to DHT11 controller
//   o_dist        last good distance
//   o_hum         last good humidity integer
//   o_temp        last good temperature integer
//   o_dist_vld    pulse: o_dist updated
//   o_env_vld     pulse: o_hum/o_temp updated
//   o_busy        FSM not idle
//   o_err         sticky: [0] SR04 timeout, [1] DHT timeout or checksum fail
//   o_state       debug view of the FSM state register
// -----------------------------------------------------------------------------
module sensor_scheduler #(
  parameter int unsigned SR04_PERIOD = 10_000_000,
  parameter int unsigned DHT_PERIOD  = 200_000_000,
  parameter int unsigned SR04_TMO    = 3_000_000,
  parameter int unsigned DHT_TMO     = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_manual_req,
  input  logic        i_sr04_done,
  input  logic [8:0]  i_sr04_dist,
  input  logic        i_dht_done,
  input  logic        i_dht_valid,
  input  logic [15:0] i_dht_hum,
  input  logic [15:0] i_dht_temp,
  output logic        o_sr04_start,
  output logic        o_dht_start,
  output logic [8:0]  o_dist,
  output logic [7:0]  o_hum,
  output logic [7:0]  o_temp,
  output logic        o_dist_vld,
  output logic        o_env_vld,
  output logic        o_busy,
  output logic [1:0]  o_err,
  output logic [2:0]  o_state
);

  localparam int SPW = $clog2(SR04_PERIOD);
  localparam int DPW = $clog2(DHT_PERIOD);
  localparam int STW = (SR04_TMO > 1) ? $clog2(SR04_TMO) : 1;
  localparam int DTW = (DHT_TMO > 1) ? $clog2(DHT_TMO) : 1;
  // One timeout counter is shared: only one sensor can be waiting at a time.
  localparam int TW  = (STW > DTW) ? STW : DTW;

  localparam logic [SPW-1:0] SR04_CNT_LAST = SPW'(SR04_PERIOD - 1);
  localparam logic [DPW-1:0] DHT_CNT_LAST  = DPW'(DHT_PERIOD - 1);
  localparam logic [TW-1:0]  SR04_TMO_LAST = TW'(SR04_TMO - 1);
  localparam logic [TW-1:0]  DHT_TMO_LAST  = TW'(DHT_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DHT_START  = 3'd1,
    S_DHT_WAIT   = 3'd2,
    S_SR04_START = 3'd3,
    S_SR04_WAIT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SPW-1:0]   sr04_cnt_q, sr04_cnt_d;
  logic [DPW-1:0]   dht_cnt_q, dht_cnt_d;
  logic             sr04_pend_q, sr04_pend_d;
  logic             dht_pend_q, dht_pend_d;
  logic             en_q;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [8:0]       dist_q, dist_d;
  logic [7:0]       hum_q, hum_d;
  logic [7:0]       temp_q, temp_d;
  logic             dist_vld_q, dist_vld_d;
  logic             env_vld_q, env_vld_d;
  logic [1:0]       err_q, err_d;

  logic             sr04_tick, dht_tick;
  logic             sr04_clr, dht_clr;
  logic             sr04_start, dht_start;
  logic             en_fall;

  // Fractional parts of the DHT11 words are not displayed.
  logic unused_frac;
  assign unused_frac = ^{i_dht_hum[7:0], i_dht_temp[7:0]};

  // ---------------------------------------------------------------------------
  // Period timers. Each one wraps at PERIOD-1 and raises a tick. While the
  // timers are disabled they are held at zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    sr04_tick  = i_enable && (sr04_cnt_q == SR04_CNT_LAST);
    dht_tick   = i_enable && (dht_cnt_q == DHT_CNT_LAST);
    sr04_cnt_d = '0;
    dht_cnt_d  = '0;
    if (i_enable && !sr04_tick) sr04_cnt_d = sr04_cnt_q + SPW'(1);
    if (i_enable && !dht_tick)  dht_cnt_d  = dht_cnt_q + DPW'(1);
  end

  // ---------------------------------------------------------------------------
  // Pending flags. Timer-raised requests that are still unserved are dropped
  // when the timers are switched off (the 1->0 edge of i_enable). A later
  // manual request while disabled is still honoured. A set in the same cycle
  // as a clear wins, so a request that arrives while its own sensor is starting
  // gets one more run.
  // ---------------------------------------------------------------------------
  assign en_fall = en_q && !i_enable;

  always_comb begin
    sr04_pend_d = sr04_pend_q;
    dht_pend_d  = dht_pend_q;
    if (en_fall) begin
      sr04_pend_d = 1'b0;
      dht_pend_d  = 1'b0;
    end
    if (sr04_clr) sr04_pend_d = 1'b0;
    if (dht_clr)  dht_pend_d  = 1'b0;
    if (sr04_tick || i_manual_req) sr04_pend_d = 1'b1;
    if (dht_tick  || i_manual_req) dht_pend_d  = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM: next state, result latching and error flags.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    dist_d     = dist_q;
    hum_d      = hum_q;
    temp_d     = temp_q;
    dist_vld_d = 1'b0;
    env_vld_d  = 1'b0;
    err_d      = err_q;
    sr04_start = 1'b0;
    dht_start  = 1'b0;
    sr04_clr   = 1'b0;
    dht_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // DHT has priority. Its period is long, so it is rarely pending.
        if (dht_pend_q)       state_d = S_DHT_START;
        else if (sr04_pend_q) state_d = S_SR04_START;
      end
      S_DHT_START: begin
        dht_start = 1'b1;
        dht_clr   = 1'b1;
        tmo_d     = '0;
        state_d   = S_DHT_WAIT;
      end
      S_DHT_WAIT: begin
        // A done in the expiry cycle still counts as a completed transaction.
        if (i_dht_done) begin
          if (i_dht_valid) begin
            hum_d     = i_dht_hum[15:8];
            temp_d    = i_dht_temp[15:8];
            env_vld_d = 1'b1;
          end else begin
            err_d[1] = 1'b1;
          end
          state_d = S_IDLE;
        end else if (tmo_q == DHT_TMO_LAST) begin
          err_d[1] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SR04_START: begin
        sr04_start = 1'b1;
        sr04_clr   = 1'b1;
        tmo_d      = '0;
        state_d    = S_SR04_WAIT;
      end
      S_SR04_WAIT: begin
        if (i_sr04_done) begin
          dist_d     = i_sr04_dist;
          dist_vld_d = 1'b1;
          state_d    = S_IDLE;
        end else if (tmo_q == SR04_TMO_LAST) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sr04_cnt_q  <= '0;
      dht_cnt_q   <= '0;
      sr04_pend_q <= 1'b0;
      dht_pend_q  <= 1'b0;
      en_q        <= 1'b0;
      tmo_q       <= '0;
      dist_q      <= '0;
      hum_q       <= '0;
      temp_q      <= '0;
      dist_vld_q  <= 1'b0;
      env_vld_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sr04_cnt_q  <= sr04_cnt_d;
      dht_cnt_q   <= dht_cnt_d;
      sr04_pend_q <= sr04_pend_d;
      dht_pend_q  <= dht_pend_d;
      en_q        <= i_enable;
      tmo_q       <= tmo_d;
      dist_q      <= dist_d;
      hum_q       <= hum_d;
      temp_q      <= temp_d;
      dist_vld_q  <= dist_vld_d;
      env_vld_q   <= env_vld_d;
      err_q       <= err_d;
    end
  end

  // Start pulses are decoded from the registered state. Each START state
  // lasts exactly one cycle, so each pulse is one cycle wide and the two
  // pulses can never overlap.
  assign o_sr04_start = sr04_start;
  assign o_dht_start  = dht_start;
  assign o_dist       = dist_q;
  assign o_hum        = hum_q;
  assign o_temp       = temp_q;
  assign o_dist_vld   = dist_vld_q;
  assign o_env_vld    = env_vld_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_err        = err_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_sensor_scheduler.sv
module tb_sensor_scheduler;

  localparam int SP = 20;
  localparam int DP = 100;
  localparam int ST = 8;
  localparam int DT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_manual_req;
  logic        i_sr04_done;
  logic [8:0]  i_sr04_dist;
  logic        i_dht_done, i_dht_valid;
  logic [15:0] i_dht_hum, i_dht_temp;
  logic        o_sr04_start, o_dht_start;
  logic [8:0]  o_dist;
  logic [7:0]  o_hum, o_temp;
  logic        o_dist_vld, o_env_vld, o_busy;
  logic [1:0]  o_err;
  logic [2:0]  o_state;

  int n_checks = 0;
  int n_errors = 0;

  sensor_scheduler #(
    .SR04_PERIOD(SP), .DHT_PERIOD(DP), .SR04_TMO(ST), .DHT_TMO(DT)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_manual_req(i_manual_req),
    .i_sr04_done(i_sr04_done), .i_sr04_dist(i_sr04_dist),
    .i_dht_done(i_dht_done), .i_dht_valid(i_dht_valid),
    .i_dht_hum(i_dht_hum), .i_dht_temp(i_dht_temp),
    .o_sr04_start(o_sr04_start), .o_dht_start(o_dht_start),
    .o_dist(o_dist), .o_hum(o_hum), .o_temp(o_temp),
    .o_dist_vld(o_dist_vld), .o_env_vld(o_env_vld), .o_busy(o_busy),
    .o_err(o_err), .o_state(o_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. m_act: 0 none, 1 SR04, 2 DHT. m_age counts cycles
  // since the start pulse (0 = start cycle, 1..TMO = waiting). m_run counts
  // consecutive enabled clock edges, and a period expires at every multiple.
  // ---------------------------------------------------------------------------
  int         m_act, m_age, m_run;
  logic       m_ps, m_pd, m_en_prev;
  logic [8:0] m_dist;
  logic [7:0] m_hum, m_temp;
  logic       m_dvld, m_evld;
  logic [1:0] m_err;

  always @(posedge clk or negedge rst) begin
    logic old_ps, old_pd, tick_s, tick_d;
    if (!rst) begin
      m_act = 0; m_age = 0; m_run = 0;
      m_ps = 0; m_pd = 0; m_en_prev = 0;
      m_dist = 0; m_hum = 0; m_temp = 0;
      m_dvld = 0; m_evld = 0; m_err = 0;
    end else begin
      old_ps = m_ps;
      old_pd = m_pd;
      if (i_enable) m_run = m_run + 1; else m_run = 0;
      tick_s = i_enable && (m_run % SP == 0);
      tick_d = i_enable && (m_run % DP == 0);
      if (m_en_prev && !i_enable) begin m_ps = 0; m_pd = 0; end
      if (m_act == 1 && m_age == 0) m_ps = 0;
      if (m_act == 2 && m_age == 0) m_pd = 0;
      if (tick_s || i_manual_req) m_ps = 1;
      if (tick_d || i_manual_req) m_pd = 1;
      m_en_prev = i_enable;
      m_dvld = 0;
      m_evld = 0;
      if (m_act == 0) begin
        if (old_pd)      begin m_act = 2; m_age = 0; end
        else if (old_ps) begin m_act = 1; m_age = 0; end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (m_act == 1) begin
        if (i_sr04_done) begin
          m_dist = i_sr04_dist; m_dvld = 1; m_act = 0;
        end else if (m_age == ST) begin
          m_err[0] = 1; m_act = 0;
        end else m_age = m_age + 1;
      end else begin
        if (i_dht_done) begin
          if (i_dht_valid) begin
            m_hum = i_dht_hum[15:8]; m_temp = i_dht_temp[15:8]; m_evld = 1;
          end else m_err[1] = 1;
          m_act = 0;
        end else if (m_age == DT) begin
          m_err[1] = 1; m_act = 0;
        end else m_age = m_age + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: every output against the model on every falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    check("sr04_start", o_sr04_start, (m_act == 1 && m_age == 0));
    check("dht_start",  o_dht_start,  (m_act == 2 && m_age == 0));
    check("busy",       o_busy,       (m_act != 0));
    check("dist",       o_dist,       m_dist);
    check("hum",        o_hum,        m_hum);
    check("temp",       o_temp,       m_temp);
    check("dist_vld",   o_dist_vld,   m_dvld);
    check("env_vld",    o_env_vld,    m_evld);
    check("err",        o_err,        m_err);
    check("start_overlap", o_sr04_start & o_dht_start, 0);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on falling edges)
  // ---------------------------------------------------------------------------
  task automatic wait_ss(input int bound, output int cyc);
    cyc = 0;
    while (o_sr04_start !== 1'b1 && cyc < bound) begin
      @(negedge clk); cyc++;
    end
    check("sr04_start_seen", o_sr04_start, 1);
  endtask

  task automatic wait_ds(input int bound, output int cyc);
    cyc = 0;
    while (o_dht_start !== 1'b1 && cyc < bound) begin
      @(negedge clk); cyc++;
    end
    check("dht_start_seen", o_dht_start, 1);
  endtask

  task automatic wait_idle(input int bound);
    int cyc = 0;
    while (o_busy !== 1'b0 && cyc < bound) begin
      @(negedge clk); cyc++;
    end
    check("idle_reached", o_busy, 0);
  endtask

  task automatic manual_pulse();
    i_manual_req = 1'b1;
    @(negedge clk);
    i_manual_req = 1'b0;
  endtask

  task automatic sr04_respond(input int n, input logic [8:0] d);
    repeat (n) @(negedge clk);
    i_sr04_done = 1'b1; i_sr04_dist = d;
    @(negedge clk);
    i_sr04_done = 1'b0; i_sr04_dist = '0;
  endtask

  task automatic dht_respond(input int n, input logic v, input logic [15:0] h, input logic [15:0] t);
    repeat (n) @(negedge clk);
    i_dht_done = 1'b1; i_dht_valid = v; i_dht_hum = h; i_dht_temp = t;
    @(negedge clk);
    i_dht_done = 1'b0; i_dht_valid = 1'b0; i_dht_hum = '0; i_dht_temp = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    rst = 1'b0; i_enable = 1'b0; i_manual_req = 1'b0;
    i_sr04_done = 1'b0; i_sr04_dist = '0;
    i_dht_done = 1'b0; i_dht_valid = 1'b0; i_dht_hum = '0; i_dht_temp = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_dist", o_dist, 0);
    check("rst_err",  o_err, 0);

    // 1: periodic SR04, done on the third wait cycle
    i_enable = 1'b1; rst = 1'b1;
    wait_ss(40, cyc);
    check("s1_first_start_cycle", cyc, 21);
    sr04_respond(3, 9'd123);
    check("s1_dist", o_dist, 123);
    check("s1_dist_vld", o_dist_vld, 1);
    @(negedge clk);
    check("s1_dist_vld_once", o_dist_vld, 0);
    i_enable = 1'b0;
    wait_idle(20);

    // 2: manual request, DHT first then SR04 immediately after
    manual_pulse();
    wait_ds(5, cyc);
    check("s2_dht_first", cyc, 1);
    dht_respond(2, 1'b1, 16'h2D00, 16'h1900);
    check("s2_hum", o_hum, 45);
    check("s2_temp", o_temp, 25);
    check("s2_env_vld", o_env_vld, 1);
    wait_ss(3, cyc);
    check("s2_sr04_follows", cyc, 1);
    sr04_respond(1, 9'd77);
    check("s2_dist", o_dist, 77);

    // 3: SR04 timeout, next period still runs
    wait_idle(20);
    i_enable = 1'b1;
    wait_ss(40, cyc);
    wait_idle(20);
    check("s3_err0", o_err[0], 1);
    check("s3_dist_kept", o_dist, 77);
    wait_ss(30, cyc);
    check("s3_err0_sticky", o_err[0], 1);
    sr04_respond(2, 9'd200);
    i_enable = 1'b0;
    wait_idle(20);

    // 4: DHT checksum failure; SR04 done in the timeout-expiry cycle
    manual_pulse();
    wait_ds(5, cyc);
    dht_respond(1, 1'b0, 16'hFF00, 16'hEE00);
    check("s4_err1", o_err[1], 1);
    check("s4_hum_kept", o_hum, 45);
    check("s4_temp_kept", o_temp, 25);
    check("s4_no_env_vld", o_env_vld, 0);
    wait_ss(3, cyc);
    sr04_respond(8, 9'd250);
    check("s4_done_at_expiry", o_dist, 250);
    wait_idle(20);

    // 5: spurious SR04 done during DHT wait; simultaneous period expiry
    manual_pulse();
    wait_ds(5, cyc);
    @(negedge clk);
    i_sr04_done = 1'b1; i_sr04_dist = 9'd5;
    @(negedge clk);
    i_sr04_done = 1'b0; i_sr04_dist = '0;
    dht_respond(1, 1'b1, 16'h3C00, 16'h1400);
    check("s5_spurious_ignored", o_dist, 250);
    check("s5_hum", o_hum, 60);
    check("s5_temp", o_temp, 20);
    wait_ss(3, cyc);
    sr04_respond(1, 9'd200);
    wait_idle(20);
    i_enable = 1'b1;
    repeat (101) @(negedge clk);
    check("s5_dht_wins", o_dht_start, 1);
    check("s5_sr04_waits", o_sr04_start, 0);
    dht_respond(1, 1'b1, 16'h2000, 16'h1500);
    check("s5_hum2", o_hum, 32);
    wait_ss(3, cyc);
    check("s5_sr04_after_dht", cyc, 1);
    sr04_respond(1, 9'd300);
    wait_idle(20);
    i_enable = 1'b0;
    @(negedge clk);

    // 6: asynchronous reset during SR04 wait, then scenario 1 again
    i_enable = 1'b1;
    wait_ss(40, cyc);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("s6_busy", o_busy, 0);
    check("s6_start", o_sr04_start, 0);
    check("s6_dist", o_dist, 0);
    check("s6_err", o_err, 0);
    check("s6_hum", o_hum, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_ss(40, cyc);
    check("s6_first_start_cycle", cyc, 21);
    sr04_respond(3, 9'd123);
    check("s6_dist_after", o_dist, 123);
    check("s6_dist_vld", o_dist_vld, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
